// File: rtl/fetch_controller_pkg.sv
// Shared widths, opcodes, FSM states and instruction field positions
// for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 29;
    localparam int OPC_W   = 5;

    localparam logic [OPC_W-1:0] NOP_OPC  = 5'd0;
    localparam logic [OPC_W-1:0] HALT_OPC = 5'b11111;

    localparam int OPC_LSB  = 24;
    localparam int DST_LSB  = 16;
    localparam int SRC1_LSB = 8;
    localparam int SRC2_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED
    } state_e;

    function automatic logic [OPC_W-1:0] get_opc(
        input logic [INSTR_W-1:0] instr
    );
        return instr[OPC_LSB +: OPC_W];
    endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-side bundle: control, program-memory port and the
// valid/ready path towards execute.
interface fetch_controller_if;
    import fetch_pkg::*;

    logic               in_start;
    logic [ADDR_W-1:0]  in_start_addr;
    logic [INSTR_W-1:0] in_mem_instr;
    logic               in_ready;
    logic               in_branch_valid;
    logic [ADDR_W-1:0]  in_branch_target;
    logic [ADDR_W-1:0]  out_mem_addr;
    logic [INSTR_W-1:0] out_instr;
    logic               out_valid;
    logic               out_halted;

    modport master (
        input  in_start,
        input  in_start_addr,
        input  in_mem_instr,
        input  in_ready,
        input  in_branch_valid,
        input  in_branch_target,
        output out_mem_addr,
        output out_instr,
        output out_valid,
        output out_halted
    );

    modport slave (
        output in_start,
        output in_start_addr,
        output in_mem_instr,
        output in_ready,
        output in_branch_valid,
        output in_branch_target,
        input  out_mem_addr,
        input  out_instr,
        input  out_valid,
        input  out_halted
    );

endinterface

// File: rtl/fetch_controller_pc_register.sv
// Program counter with load, increment and natural wrap at 2^ADDR_W.
module pc_register
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_addr;
        end else if (inc) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, registers fetched words
// and offers them to execute; handles start, branch and HALT.
module fetch_controller
    import fetch_pkg::*;
(
    input  logic              in_clk,
    input  logic              in_rst_n,
    fetch_controller_if.master bus
);

    state_e             state_d, state_q;
    logic [INSTR_W-1:0] instr_d, instr_q;
    logic               valid_d, valid_q;
    logic               halted_d, halted_q;

    logic               pc_load;
    logic [ADDR_W-1:0]  pc_load_addr;
    logic               pc_inc;
    logic [ADDR_W-1:0]  pc;
    logic               fire;
    logic               capture;
    logic               is_halt;

    pc_register u_pc (
        .clk       (in_clk),
        .rst_n     (in_rst_n),
        .load      (pc_load),
        .load_addr (pc_load_addr),
        .inc       (pc_inc),
        .pc        (pc)
    );

    assign fire    = valid_q & bus.in_ready & ~bus.in_branch_valid;
    assign capture = ~valid_q | fire;
    assign is_halt = (get_opc(bus.in_mem_instr) == HALT_OPC);

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        valid_d      = valid_q;
        halted_d     = halted_q;
        pc_load      = 1'b0;
        pc_load_addr = bus.in_start_addr;
        pc_inc       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_start) begin
                    pc_load = 1'b1;
                    valid_d = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Start beats branch; both beat fire and HALT detection.
                if (bus.in_start) begin
                    pc_load = 1'b1;
                    valid_d = 1'b0;
                end else if (bus.in_branch_valid) begin
                    pc_load      = 1'b1;
                    pc_load_addr = bus.in_branch_target;
                    valid_d      = 1'b0;
                end else if (capture) begin
                    if (is_halt) begin
                        valid_d  = 1'b0;
                        halted_d = 1'b1;
                        state_d  = ST_HALTED;
                    end else begin
                        instr_d = bus.in_mem_instr;
                        valid_d = 1'b1;
                        pc_inc  = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                if (bus.in_start) begin
                    pc_load  = 1'b1;
                    halted_d = 1'b0;
                    state_d  = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q  <= ST_IDLE;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign bus.out_mem_addr = pc;
    assign bus.out_instr    = instr_q;
    assign bus.out_valid    = valid_q;
    assign bus.out_halted   = halted_q;

endmodule
